// File: rtl/mul_div.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One bit per cycle: shift-add multiply, restoring divide on magnitudes.
module mul_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_wr,
   input  logic        lo_wr,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic        div_q;
   logic        qneg_q;
   logic        rneg_q;
   logic [31:0] x_q;
   logic [31:0] y_q;
   logic [31:0] m_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] sum;
   logic [32:0] shf;
   logic [32:0] dif;
   logic        ge;
   logic [31:0] x_d;
   logic [31:0] y_d;
   logic [63:0] prod;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   // 0x80000000 negates to itself, which reads as 2^31 unsigned
   assign a_mag = (op[0] && a[31]) ? -a : a;
   assign b_mag = (op[0] && b[31]) ? -b : b;

   always_comb begin
      sum = {1'b0, x_q} + (y_q[0] ? {1'b0, m_q} : 33'd0);
      shf = {x_q, y_q[31]};
      dif = shf - {1'b0, m_q};
      ge  = (shf >= {1'b0, m_q});
      if (div_q) begin
         x_d = ge ? dif[31:0] : shf[31:0];
         y_d = {y_q[30:0], ge};
      end else begin
         x_d = sum[32:1];
         y_d = {sum[0], y_q[31:1]};
      end
      prod = {x_d, y_d};
      if (qneg_q)
         prod = -prod;
      if (div_q) begin
         res_lo = qneg_q ? -y_d : y_d;
         res_hi = rneg_q ? -x_d : x_d;
      end else begin
         res_lo = prod[31:0];
         res_hi = prod[63:32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  div_q   <= op[1];
                  // a zero divisor keeps the all-ones quotient unsigned
                  qneg_q  <= op[0] & (a[31] ^ b[31]) & ~(op[1] & (b == 32'd0));
                  rneg_q  <= op[1] & op[0] & a[31];
                  x_q     <= '0;
                  y_q     <= op[1] ? a_mag : b_mag;
                  m_q     <= op[1] ? b_mag : a_mag;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end else begin
                  if (hi_wr)
                     hi_q <= a;
                  if (lo_wr)
                     lo_q <= a;
               end
            end
            RUN: begin
               x_q   <= x_d;
               y_q   <= y_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  hi_q    <= res_hi;
                  lo_q    <= res_lo;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_mul_div.sv
// Bench for mul_div: directed table, corner sequences, random vs model.
module tb_mul_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        hi_wr = 1'b0;
   logic        lo_wr = 1'b0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   mul_div dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .hi(hi), .lo(lo),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(string n, logic [1:0] o, logic [31:0] x,
                               logic [31:0] y, logic [31:0] h, logic [31:0] l);
      vec_t v;
      v.name = n; v.op = o; v.a = x; v.b = y; v.eh = h; v.el = l;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values
   function automatic logic [63:0] model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'd0: p = {32'd0, x} * {32'd0, y};
         2'd1: p = sx * sy;
         2'd2: p = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
         default: begin
            if (y == 0) p = {x, 32'hFFFFFFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl, output int lat);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 60) begin
         @(posedge clk);
         #1 lat++;
      end
      rh = hi; rl = lo;
      @(posedge clk);
      #1;
      chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      logic [31:0] rh, rl, x, y;
      logic [1:0]  o;
      logic [63:0] e;
      int lat, t0, t1, k;
      logic stable;

      tv.push_back(mk("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001));
      tv.push_back(mk("mult_m3x7", 2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB));
      tv.push_back(mk("div_m7d2", 2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD));
      tv.push_back(mk("divu_by0", 2'd2, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF));
      tv.push_back(mk("div_ovf", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000));
      tv.push_back(mk("mult_min2", 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0));
      tv.push_back(mk("mult_minx1", 2'd1, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h80000000));
      tv.push_back(mk("div_7dm2", 2'd3, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD));
      tv.push_back(mk("div_m7by0", 2'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF));
      tv.push_back(mk("div_minby0", 2'd3, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF));
      tv.push_back(mk("divu_maxd1", 2'd2, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF));
      tv.push_back(mk("divu_5d7", 2'd2, 32'd5, 32'd7, 32'd5, 32'd0));
      tv.push_back(mk("multu_zero", 2'd0, 32'd0, 32'h12345678, 32'd0, 32'd0));

      // reset state
      #12;
      chk("reset_state", {hi, lo}, 64'd0);
      chk("reset_flags", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tv[i]) begin
         run_op(tv[i].op, tv[i].a, tv[i].b, rh, rl, lat);
         chk({tv[i].name, "_hi"}, {32'd0, rh}, {32'd0, tv[i].eh});
         chk({tv[i].name, "_lo"}, {32'd0, rl}, {32'd0, tv[i].el});
         chk({tv[i].name, "_lat"}, 64'(lat), 64'd33);
      end

      // MTHI / MTLO, both together, and start priority over writes
      @(negedge clk);
      hi_wr = 1'b1; lo_wr = 1'b1; a = 32'hCAFEF00D;
      @(negedge clk);
      hi_wr = 1'b0; lo_wr = 1'b0;
      chk("mthi_mtlo", {hi, lo}, {32'hCAFEF00D, 32'hCAFEF00D});
      lo_wr = 1'b1; a = 32'h0BADBEEF;
      @(negedge clk);
      lo_wr = 1'b0;
      chk("mtlo_only", {hi, lo}, {32'hCAFEF00D, 32'h0BADBEEF});
      hi_wr = 1'b1; a = 32'h12345678;
      @(negedge clk);
      hi_wr = 1'b0;
      chk("mthi", {32'd0, hi}, {32'd0, 32'h12345678});

      // DIVU 10/3 with write attempts mid-RUN; hi held until done
      start = 1'b1; hi_wr = 1'b1; op = 2'd2; a = 32'd10; b = 32'd3;
      @(negedge clk);
      start = 1'b0; hi_wr = 1'b0;
      chk("start_prio", {32'd0, hi}, {32'd0, 32'h12345678});
      stable = 1'b1;
      k = 0;
      while (!done && k < 60) begin
         if (k == 5) begin hi_wr = 1'b1; lo_wr = 1'b1; a = 32'hDEADBEEF; end
         if (k == 6) begin hi_wr = 1'b0; lo_wr = 1'b0; end
         if (k == 7) begin start = 1'b1; op = 2'd0; end
         if (k == 8) start = 1'b0;
         if (hi != 32'h12345678 || lo != 32'h0BADBEEF) stable = 1'b0;
         @(negedge clk);
         k++;
      end
      chk("hold_in_run", {63'd0, stable}, 64'd1);
      chk("divu_10d3", {hi, lo}, {32'd1, 32'd3});
      @(negedge clk);
      chk("no_queued_op", {63'd0, busy}, 64'd0);

      // abort mid-RUN with async reset
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_clear", {hi, lo}, 64'd0);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(2'd0, 32'd2, 32'd3, rh, rl, lat);
      chk("after_rst", {rh, rl}, {32'd0, 32'd6});
      chk("after_rst_lat", 64'(lat), 64'd33);

      // start held high: one done pulse every 34 cycles
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
      t0 = -1; t1 = -1; k = 0;
      while (t1 < 0 && k < 120) begin
         @(negedge clk);
         k++;
         if (done) begin
            if (t0 < 0) t0 = cyc; else t1 = cyc;
         end
      end
      start = 1'b0;
      chk("held_period", 64'(t1 - t0), 64'd34);
      chk("held_result", {hi, lo}, {32'd0, 32'd12});
      k = 0;
      while (busy && k < 60) begin @(negedge clk); k++; end

      // randomized operations against the model
      for (int i = 0; i < 150; i++) begin
         o = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: x = 32'h80000000;
            1: x = 32'hFFFFFFFF;
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: y = 32'hFFFFFFFF;
            2: y = 32'($urandom_range(1, 20));
            default: y = $urandom;
         endcase
         e = model(o, x, y);
         run_op(o, x, y, rh, rl, lat);
         chk($sformatf("rand%0d_op%0d_%h_%h", i, o, x, y), {rh, rl}, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
